// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the image-memory arbiter: requester IDs, tag width and default widths.
package mem_arbiter_pkg;

    localparam int unsigned DefAddrW = 16;
    localparam int unsigned DefDataW = 16;
    localparam int unsigned TagW     = 2;

    typedef enum logic [TagW-1:0] {
        IdNone = 2'd0,
        IdVga  = 2'd1,
        IdHost = 2'd2,
        IdZoom = 2'd3
    } req_id_e;

endpackage

// File: rtl/starve_counter.sv
// Saturating wait counter: counts cycles a requester waits ungranted; o_sat forces it through.
module starve_counter #(
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_req,
    input  logic i_gnt,
    output logic o_sat
);

    localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_next;

    assign o_sat = (r_cnt == CntW'(STARVE_MAX));

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_gnt) begin
            w_cnt_next = '0;
        end else if (i_req && !o_sat) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way image-memory arbiter: VGA priority, host/zoom round robin, starvation override,
// registered memory command port and a requester-tag pipeline that steers read data back.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              zoom_req,
    input  logic              zoom_we,
    input  logic [ADDR_W-1:0] zoom_addr,
    input  logic [DATA_W-1:0] zoom_wdata,
    output logic              zoom_gnt,
    output logic              zoom_rvalid,
    output logic [DATA_W-1:0] zoom_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              w_host_sat;
    logic              w_zoom_sat;
    logic              w_host_force;
    logic              w_zoom_force;
    logic              r_prefer_zoom;
    req_id_e           w_winner;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_sel_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    req_id_e           r_tag [0:RD_LAT];

    starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_host_wait (
        .clock   (clock),
        .reset_n (reset_n),
        .i_req   (host_req),
        .i_gnt   (host_gnt),
        .o_sat   (w_host_sat)
    );

    starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_zoom_wait (
        .clock   (clock),
        .reset_n (reset_n),
        .i_req   (zoom_req),
        .i_gnt   (zoom_gnt),
        .o_sat   (w_zoom_sat)
    );

    assign w_host_force = host_req && w_host_sat;
    assign w_zoom_force = zoom_req && w_zoom_sat;

    // A starved requester outranks VGA; the round-robin pointer breaks every host/zoom tie.
    always_comb begin
        w_winner = IdNone;
        if (!reset_n) begin
            w_winner = IdNone;
        end else if (w_host_force && w_zoom_force) begin
            w_winner = r_prefer_zoom ? IdZoom : IdHost;
        end else if (w_host_force) begin
            w_winner = IdHost;
        end else if (w_zoom_force) begin
            w_winner = IdZoom;
        end else if (vga_req) begin
            w_winner = IdVga;
        end else if (host_req && zoom_req) begin
            w_winner = r_prefer_zoom ? IdZoom : IdHost;
        end else if (host_req) begin
            w_winner = IdHost;
        end else if (zoom_req) begin
            w_winner = IdZoom;
        end
    end

    assign vga_gnt  = (w_winner == IdVga);
    assign host_gnt = (w_winner == IdHost);
    assign zoom_gnt = (w_winner == IdZoom);

    always_comb begin
        w_sel_addr  = r_mem_addr;
        w_sel_wdata = r_mem_wdata;
        w_sel_we    = 1'b0;
        unique case (w_winner)
            IdVga: begin
                w_sel_addr = vga_addr;
            end
            IdHost: begin
                w_sel_addr  = host_addr;
                w_sel_wdata = host_wdata;
                w_sel_we    = host_we;
            end
            IdZoom: begin
                w_sel_addr  = zoom_addr;
                w_sel_wdata = zoom_wdata;
                w_sel_we    = zoom_we;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_mem_we      <= 1'b0;
            r_prefer_zoom <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (w_winner != IdNone) begin
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
                r_mem_we    <= w_sel_we;
            end
            if (w_winner == IdHost) begin
                r_prefer_zoom <= 1'b1;
            end else if (w_winner == IdZoom) begin
                r_prefer_zoom <= 1'b0;
            end
        end
    end

    // Stage 0 holds the tag of the read now on the memory port; stage RD_LAT meets its data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= int'(RD_LAT); i++) begin
                r_tag[i] <= IdNone;
            end
        end else begin
            r_tag[0] <= w_sel_we ? IdNone : w_winner;
            for (int i = 1; i <= int'(RD_LAT); i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;

    assign vga_rvalid  = (r_tag[RD_LAT] == IdVga);
    assign host_rvalid = (r_tag[RD_LAT] == IdHost);
    assign zoom_rvalid = (r_tag[RD_LAT] == IdZoom);

    assign vga_rdata  = mem_rdata;
    assign host_rdata = mem_rdata;
    assign zoom_rdata = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, image memory address width; DATA_W, 16, pixel word width; RD_LAT, 1, memory read latency in clocks; STARVE_MAX, 15, wait cycles before a low-priority requester is forced through.
REQ-002 There SHALL be one clock and an asynchronous, active-low reset; these are the first two ports.
REQ-003 Ports (name  direction  width  meaning) SHALL be:
- clock  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- vga_req  in  1  VGA fetch read request
- vga_addr  in  ADDR_W  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle
- vga_rvalid  out  1  vga_rdata valid
- host_req, zoom_req  in  1  host LOAD/STORE and zoom-engine requests
- host_we, zoom_we  in  1  1 = write, 0 = read
- host_addr, zoom_addr  in  ADDR_W  request address
- host_wdata, zoom_wdata  in  DATA_W  write data
- host_gnt, zoom_gnt  out  1  request accepted this cycle
- host_rvalid, zoom_rvalid  out  1  read data valid
- vga_rdata, host_rdata, zoom_rdata  out  DATA_W  read data
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_we  out  1  memory write enable, registered
- mem_rdata  in  DATA_W  memory read data

Function
REQ-004 A requester SHALL hold req, we, addr and wdata stable until it sees gnt high; acceptance happens at the rising edge where req and gnt are both high.
REQ-005 At most one gnt SHALL be high per cycle, and gnt SHALL be combinational from req and internal state; no gnt is issued while its req is low.
REQ-006 Default priority SHALL be: VGA over host and zoom; between host and zoom, round robin using a 1-bit last-served pointer that updates on each host or zoom acceptance.
REQ-007 Each of host and zoom SHALL have a wait counter, saturating at STARVE_MAX, that increments each cycle its req is high and it is not granted, and clears when it is granted.
REQ-008 A saturated counter SHALL override VGA priority for exactly one grant; if both counters are saturated, the round-robin pointer SHALL choose between them.
REQ-009 On the accept edge, mem_addr, mem_wdata and mem_we SHALL be loaded from the winner; when there is no acceptance, mem_we SHALL be 0 and mem_addr and mem_wdata SHALL hold their values.
REQ-010 mem_we SHALL be high for exactly one cycle per accepted write, and writes SHALL produce no rvalid.
REQ-011 For each accepted read, a requester-ID tag SHALL travel through a pipeline of depth RD_LAT+1. The matching rvalid SHALL be high for exactly one cycle, 1+RD_LAT cycles after the accept cycle.
REQ-012 All *_rdata outputs SHALL carry mem_rdata directly; only rvalid qualifies them.
REQ-013 Back-to-back accepts SHALL be supported at full throughput (one per cycle), with rvalid order equal to accept order.
REQ-014 A write followed immediately by a read of the same address SHALL return the newly written data; ordering is preserved at the memory port.
REQ-015 Address values SHALL pass through unmodified; there is no wrap-around or bounds checking.

Reset
REQ-016 While reset_n is low, all gnt and rvalid outputs and mem_we SHALL be 0, mem_addr and mem_wdata SHALL be 0, wait counters SHALL be 0, the round-robin pointer SHALL favour host, and the tag pipeline SHALL be empty.
REQ-017 Reset asserted mid-transaction SHALL discard every in-flight read, so no rvalid appears after reset is released for a read accepted before reset.
REQ-018 The first grant SHALL be possible in the first cycle after reset_n deasserts.

Structure
REQ-019 A shared package SHALL hold the requester-ID encoding (NONE, VGA, HOST, ZOOM), the tag width, and the default ADDR_W and DATA_W.
REQ-020 The wait counter SHALL be the sub-module starve_counter, instantiated once for host and once for zoom; the priority and round-robin logic stays in mem_arbiter.

Verification
REQ-021 Single host read at 0x0010 with memory word 0xABCD: host_gnt is high in cycle 0, mem_addr is 0x0010 in cycle 1, host_rvalid is high in cycle 2 with host_rdata 0xABCD, and no other rvalid fires.
REQ-022 vga_req, host_req and zoom_req all high continuously: VGA wins; after 15 waiting cycles host is forced through once, the next forced grant goes to zoom, and neither waits more than STARVE_MAX+2 cycles.
REQ-023 Host and zoom both requesting, VGA idle: grants alternate host, zoom, host, zoom starting from host after reset, with one grant per cycle.
REQ-024 zoom writes 0x1234 to 0x0200, then the host reads 0x0200 on the next cycle: mem_we is high for one cycle, and host_rvalid returns 0x1234.
REQ-025 Three back-to-back reads (VGA, host, VGA) followed by reset_n pulsed low after the second accept: all rvalid outputs are 0 during and after reset, mem_we is 0, and a new VGA read after release completes normally.
